// File: rtl/proj_pkg.sv
// Shared types and helpers for the projectile pool fire scheduler.
package proj_pkg;

    typedef enum logic [1:0] {IDLE, ARM, COOLDOWN} pool_state_t;

    localparam int PROJ_MAX_SLOTS = 8;

    function automatic logic [3:0] popcount(input logic [PROJ_MAX_SLOTS-1:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < PROJ_MAX_SLOTS; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/rr_slot_picker.sv
// Combinational round-robin picker: first free slot at or above rr_ptr, wrapping.
module rr_slot_picker #(
    parameter int N_SLOTS = 4,
    parameter int PW      = $clog2(N_SLOTS)
) (
    input  logic [N_SLOTS-1:0] free_mask,
    input  logic [PW-1:0]      rr_ptr,
    output logic [PW-1:0]      sel,
    output logic               valid
);

    int idx;

    // Scan offsets from farthest to nearest so the nearest free slot is the last writer.
    always_comb begin
        sel   = '0;
        valid = 1'b0;
        idx   = 0;
        for (int i = N_SLOTS - 1; i >= 0; i--) begin
            idx = (int'(rr_ptr) + i) % N_SLOTS;
            if (free_mask[idx]) begin
                sel   = PW'(idx);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/projectile_pool_ctrl.sv
// Fire scheduler for a pool of projectile slots: press-to-launch, round-robin slot
// selection, launch confirmation with timeout, frame-counted cooldown. Define
// PROJ_AUTOFIRE_EN to relaunch while fire is held instead of once per press.
module projectile_pool_ctrl
    import proj_pkg::*;
#(
    parameter int N_SLOTS         = 4,
    parameter int COOLDOWN_FRAMES = 8,
    parameter int ARM_TIMEOUT     = 2
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         frame_clk,
    input  logic                         fire,
    input  logic [N_SLOTS-1:0]           slot_busy,
    output logic [N_SLOTS-1:0]           shoot,
    output logic                         fire_granted,
    output logic [$clog2(N_SLOTS+1)-1:0] active_count,
    output logic [15:0]                  shot_count
);

    localparam int PW  = $clog2(N_SLOTS);
    localparam int ACW = $clog2(N_SLOTS + 1);

    pool_state_t          state_q, state_d;
    logic                 frame_clk_q, tick_q, fire_q, armed_q, armed_d;
    logic [PW-1:0]        sel_q, sel_d, rr_ptr_q, rr_ptr_d, pick_sel;
    logic [7:0]           cd_q, cd_d;
    logic [3:0]           to_q, to_d;
    logic [N_SLOTS-1:0]   shoot_q, shoot_d;
    logic                 granted_q, granted_d, pick_valid, req;
    logic [ACW-1:0]       active_q, active_d;
    logic [15:0]          shots_q, shots_d;

    rr_slot_picker #(.N_SLOTS(N_SLOTS), .PW(PW)) u_picker (
        .free_mask (~slot_busy),
        .rr_ptr    (rr_ptr_q),
        .sel       (pick_sel),
        .valid     (pick_valid)
    );

`ifdef PROJ_AUTOFIRE_EN
    assign req = fire_q;
`else
    assign req = fire_q & armed_q;
`endif

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        rr_ptr_d  = rr_ptr_q;
        cd_d      = cd_q;
        to_d      = to_q;
        shoot_d   = shoot_q;
        granted_d = 1'b0;
        shots_d   = shots_q;
        armed_d   = fire_q ? armed_q : 1'b1;
        active_d  = ACW'(popcount(PROJ_MAX_SLOTS'(slot_busy)));
        unique case (state_q)
            IDLE: begin
                shoot_d = '0;
                if (req && pick_valid) begin
                    state_d = ARM;
                    sel_d   = pick_sel;
                    to_d    = 4'd0;
                    shoot_d = {{(N_SLOTS-1){1'b0}}, 1'b1} << pick_sel;
                    armed_d = 1'b0;
                end
            end
            ARM: begin
                // Confirmation takes priority over a coincident timeout tick.
                if (slot_busy[sel_q]) begin
                    state_d   = COOLDOWN;
                    shoot_d   = '0;
                    granted_d = 1'b1;
                    shots_d   = shots_q + 16'd1;
                    rr_ptr_d  = (sel_q == PW'(N_SLOTS - 1)) ? '0 : sel_q + PW'(1);
                    cd_d      = 8'(COOLDOWN_FRAMES);
                end else if (tick_q) begin
                    to_d = to_q + 4'd1;
                    if (to_d == 4'(ARM_TIMEOUT)) begin
                        state_d = IDLE;
                        shoot_d = '0;
                    end
                end
            end
            COOLDOWN: begin
                shoot_d = '0;
                if (cd_q == 8'd0) begin
                    state_d = IDLE;
                end else if (tick_q) begin
                    cd_d = cd_q - 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                shoot_d = '0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            frame_clk_q <= 1'b0;
            tick_q      <= 1'b0;
            fire_q      <= 1'b0;
            armed_q     <= 1'b1;
            sel_q       <= '0;
            rr_ptr_q    <= '0;
            cd_q        <= 8'd0;
            to_q        <= 4'd0;
            shoot_q     <= '0;
            granted_q   <= 1'b0;
            active_q    <= '0;
            shots_q     <= 16'd0;
        end else begin
            state_q     <= state_d;
            frame_clk_q <= frame_clk;
            tick_q      <= frame_clk & ~frame_clk_q;
            fire_q      <= fire;
            armed_q     <= armed_d;
            sel_q       <= sel_d;
            rr_ptr_q    <= rr_ptr_d;
            cd_q        <= cd_d;
            to_q        <= to_d;
            shoot_q     <= shoot_d;
            granted_q   <= granted_d;
            active_q    <= active_d;
            shots_q     <= shots_d;
        end
    end

    assign shoot        = shoot_q;
    assign fire_granted = granted_q;
    assign active_count = active_q;
    assign shot_count   = shots_q;

endmodule
